// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the N-master bus arbiter.
// Holds the state encoding, the policy constants and width helpers.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic POLICY_FIXED = 1'b0;
  localparam logic POLICY_RR    = 1'b1;

  function automatic int clog2_int(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Owner index width; a two-master bus still needs one bit.
  function automatic int id_width(input int num);
    return (clog2_int(num) < 1) ? 1 : clog2_int(num);
  endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational winner search over a request vector, starting at a pointer.
// The request vector is doubled so a rotated window can be scanned without wrap logic.
module arb_priority_pick
  import bus_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] start,
  input  logic            policy,
  output logic [N-1:0]    winner,
  output logic [ID_W-1:0] winner_id,
  output logic            any
);

  localparam int            ID_P1 = ID_W + 1;
  localparam logic [ID_W:0] N_W   = ID_P1'(N);

  logic [2*N-1:0]  req_dbl;
  logic [N-1:0]    req_rot;
  logic [ID_W-1:0] base;
  logic [ID_W-1:0] offset;
  logic [ID_W:0]   sum;
  logic            found;

  always_comb begin
    base    = (policy == POLICY_RR) ? start : '0;
    req_dbl = {req, req};
    req_rot = req_dbl[base +: N];
    found   = 1'b0;
    offset  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        found  = 1'b1;
        offset = i[ID_W-1:0];
      end
    end
    // Undo the rotation: base + offset lies in [0, 2N-2], so one subtract suffices.
    sum = {1'b0, base} + {1'b0, offset};
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    winner_id = sum[ID_W-1:0];
    any       = found;
    winner    = '0;
    for (int i = 0; i < N; i++) begin
      winner[i] = found && (winner_id == i[ID_W-1:0]);
    end
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: fixed or round-robin policy, grant held until release,
// optional hold limit, and one all-zero turnaround cycle between owners.
//
//   state   | meaning
//   IDLE    | no owner; any request is granted on the next edge
//   BUSY    | owner holds the bus; outputs frozen, no preemption
//   RELEASE | turnaround cycle, outputs zero; always returns to IDLE
module bus_arbiter_n
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int SLAVE_SEL_W = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_HOLD    = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_MASTERS-1:0]               m_request,
  input  logic [NUM_MASTERS*SLAVE_SEL_W-1:0]   m_slave_sel,
  output logic [NUM_MASTERS-1:0]               m_grant,
  output logic [id_width(NUM_MASTERS)-1:0]     bus_grant,
  output logic [SLAVE_SEL_W-1:0]               slave_sel,
  output logic                                 arbiter_busy,
  output logic                                 hold_timeout
);

  localparam int              ID_W    = id_width(NUM_MASTERS);
  localparam logic            POLICY  = (ROUND_ROBIN != 0) ? POLICY_RR : POLICY_FIXED;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_MASTERS - 1);

  arb_state_t             state;
  logic [ID_W-1:0]        rr_ptr;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [ID_W-1:0]        pick_id;
  logic                   pick_any;
  logic                   owner_req;
  logic                   hold_expired;

  arb_priority_pick #(
    .N    (NUM_MASTERS),
    .ID_W (ID_W)
  ) u_pick (
    .req       (m_request),
    .start     (rr_ptr),
    .policy    (POLICY),
    .winner    (pick_onehot),
    .winner_id (pick_id),
    .any       (pick_any)
  );

  assign owner_req = m_request[bus_grant];

  generate
    if (MAX_HOLD > 0) begin : g_hold
      localparam int                HOLD_W    = clog2_int(MAX_HOLD + 1);
      localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
      logic [HOLD_W-1:0] hold_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          hold_cnt <= '0;
        end else if (state == IDLE && pick_any) begin
          hold_cnt <= '0;
        end else if (state == BUSY) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end

      // Expiry on the MAX_HOLD-th BUSY edge gives a tenure of exactly MAX_HOLD cycles.
      assign hold_expired = (state == BUSY) && (hold_cnt == HOLD_LAST);
    end else begin : g_no_hold
      assign hold_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      m_grant      <= '0;
      bus_grant    <= '0;
      slave_sel    <= '0;
      arbiter_busy <= 1'b0;
      hold_timeout <= 1'b0;
    end else begin
      hold_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            m_grant      <= pick_onehot;
            bus_grant    <= pick_id;
            slave_sel    <= m_slave_sel[pick_id*SLAVE_SEL_W +: SLAVE_SEL_W];
            arbiter_busy <= 1'b1;
            rr_ptr       <= (pick_id == LAST_ID) ? '0 : pick_id + ID_W'(1);
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req || hold_expired) begin
            m_grant      <= '0;
            bus_grant    <= '0;
            slave_sel    <= '0;
            arbiter_busy <= 1'b0;
            // A voluntary drop wins over a coincident expiry: no timeout reported.
            hold_timeout <= owner_req;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          m_grant      <= '0;
          bus_grant    <= '0;
          slave_sel    <= '0;
          arbiter_busy <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) $onehot0(m_grant));
  a_busy_match:   assert property (@(posedge clk) arbiter_busy == (|m_grant));
  a_id_match:     assert property (@(posedge clk) !arbiter_busy || m_grant[bus_grant]);
  a_idle_id_zero: assert property (@(posedge clk) arbiter_busy || (bus_grant == '0));

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n: three configurations share one stimulus stream,
// each vector names the instance whose outputs it checks.
module tb_bus_arbiter_n;

  localparam logic [7:0] SEL_A = 8'b00_01_10_11;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] m_request;
  logic [7:0] m_slave_sel;

  logic [3:0] grant_fp, grant_rr, grant_to;
  logic [1:0] id_fp, id_rr, id_to;
  logic [1:0] sel_fp, sel_rr, sel_to;
  logic       busy_fp, busy_rr, busy_to;
  logic       to_fp, to_rr, to_to;

  always #5 clk = ~clk;

  bus_arbiter_n #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .ROUND_ROBIN(0), .MAX_HOLD(0)) dut_fp (
    .clk(clk), .rst(rst), .m_request(m_request), .m_slave_sel(m_slave_sel),
    .m_grant(grant_fp), .bus_grant(id_fp), .slave_sel(sel_fp),
    .arbiter_busy(busy_fp), .hold_timeout(to_fp)
  );

  bus_arbiter_n #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .ROUND_ROBIN(1), .MAX_HOLD(0)) dut_rr (
    .clk(clk), .rst(rst), .m_request(m_request), .m_slave_sel(m_slave_sel),
    .m_grant(grant_rr), .bus_grant(id_rr), .slave_sel(sel_rr),
    .arbiter_busy(busy_rr), .hold_timeout(to_rr)
  );

  bus_arbiter_n #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .ROUND_ROBIN(1), .MAX_HOLD(5)) dut_to (
    .clk(clk), .rst(rst), .m_request(m_request), .m_slave_sel(m_slave_sel),
    .m_grant(grant_to), .bus_grant(id_to), .slave_sel(sel_to),
    .arbiter_busy(busy_to), .hold_timeout(to_to)
  );

  // {grant, id, slave_sel, busy, timeout}
  typedef logic [9:0] obs_t;
  obs_t obs [3];

  always_comb begin
    obs[0] = {grant_fp, id_fp, sel_fp, busy_fp, to_fp};
    obs[1] = {grant_rr, id_rr, sel_rr, busy_rr, to_rr};
    obs[2] = {grant_to, id_to, sel_to, busy_to, to_to};
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    int         dut;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic obs_t mk(input logic [3:0] g, input logic [1:0] id,
                              input logic [1:0] ss, input logic to);
    return {g, id, ss, |g, to};
  endfunction

  // Expected outputs for a one-hot grant under the SEL_A slave-select pattern.
  function automatic obs_t exp_a(input logic [3:0] g, input logic to);
    logic [7:0] s;
    logic [1:0] id;
    logic [1:0] ss;
    s  = SEL_A;
    id = 2'd0;
    ss = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        id = i[1:0];
        ss = s[i*2 +: 2];
      end
    end
    return mk(g, id, ss, to);
  endfunction

  task automatic v(input logic r, input logic [3:0] req, input int dut, input logic [3:0] g);
    vec_t x;
    x.rst = r;
    x.req = req;
    x.dut = dut;
    x.exp = exp_a(g, 1'b0);
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int dut, input obs_t exp);
    obs_t act;
    act   = obs[dut];
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s dut%0d: got %b want %b (grant,id,sel,busy,timeout)", name, dut, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] req, input logic [7:0] sel);
    @(negedge clk);
    rst         = r;
    m_request   = req;
    m_slave_sel = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sel_b;
    logic [7:0] sel_c;
    rst         = 1'b1;
    m_request   = '0;
    m_slave_sel = SEL_A;

    // Fixed priority: lowest index wins, no preemption, one turnaround cycle.
    v(1, 4'b0000, 0, 4'b0000);
    v(0, 4'b1010, 0, 4'b0010);
    v(0, 4'b1010, 0, 4'b0010);
    v(0, 4'b1010, 0, 4'b0010);
    v(0, 4'b1000, 0, 4'b0000);
    v(0, 4'b1000, 0, 4'b0000);
    v(0, 4'b1000, 0, 4'b1000);
    v(0, 4'b1001, 0, 4'b1000);
    v(0, 4'b0001, 0, 4'b0000);
    v(0, 4'b0001, 0, 4'b0000);
    v(0, 4'b0001, 0, 4'b0001);
    v(0, 4'b0110, 0, 4'b0000);
    v(0, 4'b0110, 0, 4'b0000);
    v(0, 4'b0110, 0, 4'b0010);
    v(0, 4'b0100, 0, 4'b0000);
    v(0, 4'b0100, 0, 4'b0000);
    v(0, 4'b0100, 0, 4'b0100);
    v(0, 4'b0000, 0, 4'b0000);
    v(0, 4'b0000, 0, 4'b0000);

    // Round robin: rotation 0,1,2,3,0 then a skip from pointer 1 to master 3.
    v(1, 4'b0000, 1, 4'b0000);
    for (int m = 0; m < 4; m++) begin
      logic [3:0] g;
      logic [3:0] drop;
      g    = 4'b0001 << m;
      drop = 4'b1111 & ~g;
      v(0, 4'b1111, 1, g);
      v(0, 4'b1111, 1, g);
      v(0, 4'b1111, 1, g);
      v(0, drop,    1, 4'b0000);
      v(0, 4'b1111, 1, 4'b0000);
    end
    v(0, 4'b1111, 1, 4'b0001);
    v(0, 4'b1000, 1, 4'b0000);
    v(0, 4'b1001, 1, 4'b0000);
    v(0, 4'b1001, 1, 4'b1000);
    v(0, 4'b0001, 1, 4'b0000);
    v(0, 4'b0001, 1, 4'b0000);
    v(0, 4'b0001, 1, 4'b0001);
    v(0, 4'b0000, 1, 4'b0000);
    v(0, 4'b0000, 1, 4'b0000);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].req, SEL_A);
      check($sformatf("vec%0d", k), vecs[k].dut, vecs[k].exp);
    end

    // Latch stability: master 2 owns; master 0 requests and master 2 changes its select.
    sel_b = 8'b00_01_00_00;
    sel_c = 8'b00_11_00_10;
    step(1, 4'b0000, sel_b);
    step(0, 4'b0100, sel_b);
    check("latch_grant", 0, mk(4'b0100, 2'd2, 2'b01, 1'b0));
    for (int t = 0; t < 3; t++) begin
      step(0, 4'b0101, sel_c);
      check($sformatf("latch_hold%0d", t), 0, mk(4'b0100, 2'd2, 2'b01, 1'b0));
    end
    step(0, 4'b0001, sel_c);
    check("latch_release", 0, mk(4'b0000, 2'd0, 2'b00, 1'b0));
    step(0, 4'b0001, sel_c);
    check("latch_idle", 0, mk(4'b0000, 2'd0, 2'b00, 1'b0));
    step(0, 4'b0001, sel_c);
    check("latch_next", 0, mk(4'b0001, 2'd0, 2'b10, 1'b0));

    // Timeout with MAX_HOLD=5, masters 0 and 1 holding requests.
    step(1, 4'b0000, SEL_A);
    for (int t = 0; t < 5; t++) begin
      step(0, 4'b0011, SEL_A);
      check($sformatf("to_m0_cyc%0d", t), 2, exp_a(4'b0001, 1'b0));
    end
    step(0, 4'b0011, SEL_A);
    check("to_m0_pulse", 2, exp_a(4'b0000, 1'b1));
    step(0, 4'b0011, SEL_A);
    check("to_m0_idle", 2, exp_a(4'b0000, 1'b0));
    for (int t = 0; t < 5; t++) begin
      step(0, 4'b0011, SEL_A);
      check($sformatf("to_m1_cyc%0d", t), 2, exp_a(4'b0010, 1'b0));
    end
    check("fp_no_timeout", 0, exp_a(4'b0001, 1'b0));
    step(0, 4'b0011, SEL_A);
    check("to_m1_pulse", 2, exp_a(4'b0000, 1'b1));
    step(0, 4'b0011, SEL_A);
    check("to_m1_idle", 2, exp_a(4'b0000, 1'b0));
    step(0, 4'b0011, SEL_A);
    check("to_wrap_m0", 2, exp_a(4'b0001, 1'b0));

    // Reset mid-tenure clears outputs and the round-robin pointer.
    step(1, 4'b0000, SEL_A);
    step(0, 4'b0010, SEL_A);
    check("rst_pre_grant", 1, exp_a(4'b0010, 1'b0));
    step(1, 4'b0010, SEL_A);
    check("rst_mid_clear", 1, exp_a(4'b0000, 1'b0));
    step(0, 4'b0110, SEL_A);
    check("rst_ptr_zero", 1, exp_a(4'b0010, 1'b0));
    step(1, 4'b1000, SEL_A);
    check("rst_clear2", 1, exp_a(4'b0000, 1'b0));
    step(0, 4'b1000, SEL_A);
    check("rst_m3_grant", 1, exp_a(4'b1000, 1'b0));

    // Single-cycle pulse, then a long idle stretch.
    step(1, 4'b0000, SEL_A);
    step(0, 4'b0010, SEL_A);
    check("pulse_grant", 0, exp_a(4'b0010, 1'b0));
    step(0, 4'b0000, SEL_A);
    check("pulse_release", 0, exp_a(4'b0000, 1'b0));
    step(0, 4'b0000, SEL_A);
    check("pulse_idle", 0, exp_a(4'b0000, 1'b0));
    for (int t = 0; t < 20; t++) begin
      step(0, 4'b0000, SEL_A);
      check($sformatf("idle%0d", t), 0, exp_a(4'b0000, 1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_n.md
# bus_arbiter_n

Parametrised N-master system-bus arbiter with selectable fixed-priority or round-robin policy, grant hold until release, an optional hold-time limit, and a turnaround cycle between owners. It sits between the bus masters and the address/data decoder. The granted master's slave select is latched and held for the whole tenure, and the owner is reported both one-hot and binary.

## Interface
- `NUM_MASTERS`, 4 — number of requesting masters, 2..16.
- `SLAVE_SEL_W`, 2 — width of each master's slave-select field.
- `ROUND_ROBIN`, 1 — 1 = round-robin; 0 = fixed priority, where master 0 is highest.
- `MAX_HOLD`, 0 — maximum grant length in cycles; 0 = unlimited.
- `ID_W`, derived, = max(1, clog2(`NUM_MASTERS`)).

Ports:
- `clk` in 1 — single clock. All state changes on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `m_request` in `NUM_MASTERS` — request per master. Level-held for the whole transaction.
- `m_slave_sel` in `NUM_MASTERS*SLAVE_SEL_W` — packed slave selects. Master i occupies bits [i*W +: W].
- `m_grant` out `NUM_MASTERS` — one-hot grant, or all-zero.
- `bus_grant` out `ID_W` — binary index of the current owner. 0 when idle.
- `slave_sel` out `SLAVE_SEL_W` — slave address latched from the owner.
- `arbiter_busy` out 1 — high while any grant is held.
- `hold_timeout` out 1 — one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- **Reset.** All outputs are 0, state = IDLE, round-robin pointer = 0, hold counter = 0. Reset overrides everything, including a grant that is mid-tenure. No release cycle is inserted on reset.
- **IDLE:**
  - If `m_request` ≠ 0, select a winner, register `m_grant`, `bus_grant` and `slave_sel` (from the winner's field), set `arbiter_busy`, and move to BUSY.
  - Otherwise hold all outputs at 0.
- **Selection, fixed priority:** the lowest requesting index wins.
- **Selection, round-robin:** the first requester at or after the pointer wins, wrapping from `NUM_MASTERS-1` to 0. On each grant, pointer ← winner+1 (mod `NUM_MASTERS`).
- **BUSY:**
  - Outputs are frozen. Changes on the owner's `m_slave_sel` are ignored.
  - Requests from other masters never preempt the owner.
  - The owner deasserting its request moves the block to RELEASE.
  - With `MAX_HOLD` > 0, when the hold counter reaches `MAX_HOLD-1` and the request is still high, move to RELEASE and pulse `hold_timeout`.
- **RELEASE (one turnaround cycle):**
  - All outputs are 0 except `hold_timeout`, which may be pulsed.
  - Always proceeds to IDLE.
- **Re-request after revoke.** A master revoked by timeout that keeps its request high is treated as an ordinary requester in the next IDLE. In round-robin mode it has the lowest priority at that point.
- **Hold counter.** Cleared on grant, incremented on each BUSY edge. Width is clog2(`MAX_HOLD`+1); it does not exist when `MAX_HOLD` = 0.

## Timing
- **Grant latency.** A request sampled high at edge k in IDLE makes the grant outputs valid after edge k, i.e. registered, 1-cycle latency.
- **Release.** If the owner's request is sampled low at edge j, outputs clear after edge j. IDLE is reached after j+1, and the earliest next grant is after edge j+2.
- **Tenure with timeout.** A grant lasts exactly `MAX_HOLD` cycles when the request is held. `hold_timeout` is high for exactly the first RELEASE cycle.
- **Outputs** are driven only from registers; there are no combinational request-to-grant paths.
- **Consistency invariant.** `m_grant` has at most one bit set. `arbiter_busy` = |`m_grant`. `bus_grant` matches the set bit.
- **Simultaneous requests in IDLE** are resolved by policy in the same cycle. A request that pulses for exactly the IDLE sample edge still receives a grant, and is then released the next cycle when seen low.

## Structure
- **Package `bus_arb_pkg`:**
  - State encoding: IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2.
  - Clog2 helper function.
  - Policy constants: POLICY_FIXED = 0, POLICY_RR = 1.
- **Sub-module `arb_priority_pick`:**
  - Combinational inputs: request vector, start pointer, policy.
  - Outputs: one-hot winner, binary winner, `any`.
  - Implemented as a double-width rotate/mask search.
- **Top level:** FSM, latch registers, round-robin pointer, hold counter.

## Test plan
- **Fixed priority, N=4.** `m_request`=4'b1010 in IDLE → after 1 edge `m_grant`=4'b0010, `bus_grant`=1, `slave_sel`=master 1's field. Master 3 stays ungranted until master 1 releases.
- **Round-robin rotation.** `m_request`=4'b1111 held continuously, each owner dropping its request for one cycle after 3 BUSY cycles → grant order 0,1,2,3,0. Exactly one RELEASE cycle of all-zero outputs between owners.
- **No preemption and latch stability.** Master 2 is owner; master 0 then requests and master 2 changes its `m_slave_sel` from 2'b01 to 2'b11 → `m_grant` and `slave_sel`=2'b01 unchanged until master 2 releases.
- **Timeout.** `MAX_HOLD`=5, master 0 holds its request indefinitely → `m_grant`[0] high for exactly 5 cycles, `hold_timeout` pulses for 1 cycle. In round-robin mode master 1 (also requesting) is granted 2 edges later.
- **Reset mid-tenure.** Assert `rst` for 1 cycle while BUSY → all outputs 0 after that edge, round-robin pointer 0. With `m_request`=4'b1000 held through reset, master 3 is granted one edge after `rst` falls.
- **Single-cycle request pulse and idle.** `m_request`[1] high for one cycle in IDLE → grant for one cycle, RELEASE, IDLE. With no requests, outputs stay 0 and `arbiter_busy`=0 for 20 cycles.
